// File: rtl/dffn_pipe_bank.sv
// dffn_pipe_bank: WIDTH-bit, DEPTH-stage pipeline of falling-edge registers.
// Each stage carries a valid bit. The bank supports stall (EN), synchronous SET
// and FLUSH, and an occupancy count that always equals the number of valid stages.
// Optional scan chain over all state bits: define DFFN_PIPE_BANK_SCAN_EN to add
// the SE/SI/SO ports.
module dffn_pipe_bank #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] SET_VAL   = {WIDTH{1'b1}}
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       EN,
    input  logic                       SET,
    input  logic                       FLUSH,
    input  logic [WIDTH-1:0]           D,
    input  logic                       D_VLD,
`ifdef DFFN_PIPE_BANK_SCAN_EN
    input  logic                       SE,
    input  logic                       SI,
    output logic                       SO,
`endif
    output logic [WIDTH-1:0]           Q,
    output logic                       Q_VLD,
    output logic [$clog2(DEPTH+1)-1:0] COUNT
);

    localparam int CW = $clog2(DEPTH+1);

    // Registered state
    logic [WIDTH-1:0] data_r   [DEPTH];
    logic [DEPTH-1:0] vld_r;
    logic [CW-1:0]    cnt_r;

    // Contents after a one-stage advance
    logic [WIDTH-1:0] data_adv [DEPTH];
    logic [DEPTH-1:0] vld_adv;
    logic [CW-1:0]    cnt_adv;

    // Next state of the functional (non-scan) path
    logic [WIDTH-1:0] data_fn  [DEPTH];
    logic [DEPTH-1:0] vld_fn;
    logic [CW-1:0]    cnt_fn;

    // Next state actually loaded at the falling edge
    logic [WIDTH-1:0] data_nx  [DEPTH];
    logic [DEPTH-1:0] vld_nx;
    logic [CW-1:0]    cnt_nx;

    // Stage 0 takes the input word; every other stage takes its predecessor.
    // Invalid words shift like valid ones, so bubbles are never collapsed.
    assign data_adv[0] = D;
    assign vld_adv[0]  = D_VLD;
    for (genvar i = 1; i < DEPTH; i++) begin : g_shift
        assign data_adv[i] = data_r[i-1];
        assign vld_adv[i]  = vld_r[i-1];
    end

    // One word may enter and one may leave per advance; both together cancel.
    assign cnt_adv = cnt_r + CW'(D_VLD) - CW'(vld_r[DEPTH-1]);

    // SET over FLUSH over EN. Conditional operators are used so an unknown
    // control merges the candidate values to X instead of silently picking one.
    for (genvar i = 0; i < DEPTH; i++) begin : g_fn
        assign data_fn[i] = SET ? SET_VAL : (FLUSH ? data_r[i] : (EN ? data_adv[i] : data_r[i]));
    end
    assign vld_fn = SET ? '0 : (FLUSH ? '0 : (EN ? vld_adv : vld_r));
    assign cnt_fn = SET ? '0 : (FLUSH ? '0 : (EN ? cnt_adv : cnt_r));

`ifdef DFFN_PIPE_BANK_SCAN_EN
    localparam int SW = WIDTH + 1;
    localparam int NB = DEPTH * SW;

    logic [NB-1:0]    chain_cur;
    logic [NB-1:0]    chain_sh;
    logic [WIDTH-1:0] data_sc  [DEPTH];
    logic [DEPTH-1:0] vld_sc;

    function automatic logic [CW-1:0] popcount(input logic [DEPTH-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < DEPTH; i++) c = c + CW'(v[i]);
        return c;
    endfunction

    // Chain order per stage: valid bit first, then data LSB to MSB; stage 0 nearest SI.
    for (genvar i = 0; i < DEPTH; i++) begin : g_chain
        assign chain_cur[i*SW]            = vld_r[i];
        assign chain_cur[i*SW+1 +: WIDTH] = data_r[i];
        assign vld_sc[i]                  = chain_sh[i*SW];
        assign data_sc[i]                 = chain_sh[i*SW+1 +: WIDTH];
        assign data_nx[i]                 = SE ? data_sc[i] : data_fn[i];
    end
    assign chain_sh = {chain_cur[NB-2:0], SI};
    assign vld_nx   = SE ? vld_sc : vld_fn;
    // After a scan shift the count is rebuilt from the valid bits that landed.
    assign cnt_nx   = SE ? popcount(vld_sc) : cnt_fn;
    assign SO       = data_r[DEPTH-1][WIDTH-1];
`else
    for (genvar i = 0; i < DEPTH; i++) begin : g_nx
        assign data_nx[i] = data_fn[i];
    end
    assign vld_nx = vld_fn;
    assign cnt_nx = cnt_fn;
`endif

    // State register: asynchronous reset, otherwise load next state on falling CLK.
    always_ff @(negedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) data_r[i] <= RESET_VAL;
            vld_r <= '0;
            cnt_r <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) data_r[i] <= data_nx[i];
            vld_r <= vld_nx;
            cnt_r <= cnt_nx;
        end
    end

    assign Q     = data_r[DEPTH-1];
    assign Q_VLD = vld_r[DEPTH-1];
    assign COUNT = cnt_r;

endmodule

// File: tb/tb_dffn_pipe_bank.sv
// Bench for dffn_pipe_bank (WIDTH=8, DEPTH=3, RESET_VAL=00, SET_VAL=FF).
// A queue holds the modelled pipe contents, output end at the front.
module tb_dffn_pipe_bank;

    localparam int         WIDTH = 8;
    localparam int         DEPTH = 3;
    localparam logic [7:0] RV    = 8'h00;
    localparam logic [7:0] SV    = 8'hFF;

    logic       CLK = 1'b1;
    logic       RST;
    logic       EN;
    logic       SET;
    logic       FLUSH;
    logic [7:0] D;
    logic       D_VLD;
    logic [7:0] Q;
    logic       Q_VLD;
    logic [1:0] COUNT;
`ifdef DFFN_PIPE_BANK_SCAN_EN
    logic       SE;
    logic       SI;
    logic       SO;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [7:0] d;
        logic       v;
    } ent_t;

    ent_t pipe[$];

    dffn_pipe_bank #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .RESET_VAL(RV),
        .SET_VAL  (SV)
    ) dut (
        .CLK  (CLK),
        .RST  (RST),
        .EN   (EN),
        .SET  (SET),
        .FLUSH(FLUSH),
        .D    (D),
        .D_VLD(D_VLD),
`ifdef DFFN_PIPE_BANK_SCAN_EN
        .SE   (SE),
        .SI   (SI),
        .SO   (SO),
`endif
        .Q    (Q),
        .Q_VLD(Q_VLD),
        .COUNT(COUNT)
    );

    always #5 CLK = ~CLK;

    // Occupancy must always match the valid bits, sampled mid-cycle.
    always @(posedge CLK) begin
        if (!RST) begin
            checks++;
            if (COUNT !== 2'($countones(dut.vld_r))) begin
                errors++;
                $display("FAIL count_popcount t=%0t COUNT=%0d vld=%b", $time, COUNT, dut.vld_r);
            end
        end
    end

    function automatic void model_reset();
        ent_t e;
        pipe.delete();
        e.d = RV;
        e.v = 1'b0;
        for (int i = 0; i < DEPTH; i++) pipe.push_back(e);
    endfunction

    function automatic void model_set();
        for (int i = 0; i < DEPTH; i++) begin
            pipe[i].d = SV;
            pipe[i].v = 1'b0;
        end
    endfunction

    function automatic void model_flush();
        for (int i = 0; i < DEPTH; i++) pipe[i].v = 1'b0;
    endfunction

    function automatic void model_adv(input logic [7:0] d, input logic v);
        ent_t e;
        e.d = d;
        e.v = v;
        void'(pipe.pop_front());
        pipe.push_back(e);
    endfunction

    function automatic logic [10:0] model_out();
        int c;
        c = 0;
        for (int i = 0; i < DEPTH; i++) c += int'(pipe[i].v);
        return {pipe[0].d, pipe[0].v, 2'(c)};
    endfunction

    // Drive one set of inputs across a falling edge, then advance the model.
    task automatic cyc(input logic en, input logic set, input logic flush,
                       input logic [7:0] d, input logic dv);
        EN = en; SET = set; FLUSH = flush; D = d; D_VLD = dv;
        @(negedge CLK);
        #1;
        if (set) model_set();
        else if (flush) model_flush();
        else if (en) model_adv(d, dv);
    endtask

    task automatic test_reset();
        logic [10:0] got;
        RST = 1'b0; EN = 1'b0; SET = 1'b0; FLUSH = 1'b0; D = 8'h00; D_VLD = 1'b0;
`ifdef DFFN_PIPE_BANK_SCAN_EN
        SE = 1'b0; SI = 1'b0;
`endif
        #1 RST = 1'b1;
        #1;
        got = {Q, Q_VLD, COUNT};
        checks++;
        if (got !== 11'h000) begin
            errors++; $display("FAIL reset_init got=%h want=%h", got, 11'h000);
        end
        @(posedge CLK);
        RST = 1'b0;
        model_reset();
        cyc(1'b1, 1'b0, 1'b0, 8'h11, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 8'h22, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 8'h33, 1'b1);
        got = {Q, Q_VLD, COUNT};
        checks++;
        if (got !== {8'h11, 1'b1, 2'd3}) begin
            errors++; $display("FAIL reset_fill got=%h want=%h", got, {8'h11, 1'b1, 2'd3});
        end
        // Reset between edges must act immediately.
        @(posedge CLK);
        RST = 1'b1;
        #1;
        got = {Q, Q_VLD, COUNT};
        checks++;
        if (got !== 11'h000) begin
            errors++; $display("FAIL reset_async got=%h want=%h", got, 11'h000);
        end
        EN = 1'b1; D = 8'h77; D_VLD = 1'b1;
        @(negedge CLK);
        #1;
        got = {Q, Q_VLD, COUNT};
        checks++;
        if (got !== 11'h000) begin
            errors++; $display("FAIL reset_hold got=%h want=%h", got, 11'h000);
        end
        @(posedge CLK);
        RST = 1'b0; EN = 1'b0; D_VLD = 1'b0;
        model_reset();
    endtask

    task automatic test_fill();
        logic [7:0]  din [3];
        logic [10:0] want [3];
        logic [10:0] got;
        din  = '{8'hA1, 8'hB2, 8'hC3};
        want = '{{8'h00, 1'b0, 2'd1}, {8'h00, 1'b0, 2'd2}, {8'hA1, 1'b1, 2'd3}};
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 1'b0, din[i], 1'b1);
            got = {Q, Q_VLD, COUNT};
            checks++;
            if (got !== want[i]) begin
                errors++; $display("FAIL fill_edge%0d got=%h want=%h", i + 1, got, want[i]);
            end
        end
    endtask

    task automatic test_stall();
        logic [10:0] got;
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 8'h55, 1'b1);
            got = {Q, Q_VLD, COUNT};
            checks++;
            if (got !== {8'hA1, 1'b1, 2'd3}) begin
                errors++; $display("FAIL stall_hold%0d got=%h want=%h", i, got, {8'hA1, 1'b1, 2'd3});
            end
        end
        cyc(1'b1, 1'b0, 1'b0, 8'hD4, 1'b1);
        got = {Q, Q_VLD, COUNT};
        checks++;
        if (got !== {8'hB2, 1'b1, 2'd3}) begin
            errors++; $display("FAIL stall_resume got=%h want=%h", got, {8'hB2, 1'b1, 2'd3});
        end
    endtask

    task automatic test_set_flush();
        logic [10:0] want [5];
        logic [10:0] got;
        want = '{{8'hFF, 1'b0, 2'd0}, {8'hFF, 1'b0, 2'd1}, {8'hFF, 1'b0, 2'd0},
                 {8'hFF, 1'b0, 2'd0}, {8'h3C, 1'b0, 2'd0}};
        for (int i = 0; i < 5; i++) begin
            case (i)
                0:       cyc(1'b1, 1'b1, 1'b1, 8'h99, 1'b1);
                1:       cyc(1'b1, 1'b0, 1'b0, 8'h3C, 1'b1);
                2:       cyc(1'b0, 1'b0, 1'b1, 8'h5A, 1'b1);
                default: cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
            endcase
            got = {Q, Q_VLD, COUNT};
            checks++;
            if (got !== want[i]) begin
                errors++; $display("FAIL set_flush_step%0d got=%h want=%h", i, got, want[i]);
            end
        end
    endtask

    task automatic test_alternate();
        logic [10:0] want [6];
        logic [10:0] got;
        want = '{{8'h00, 1'b0, 2'd1}, {8'h00, 1'b0, 2'd1}, {8'h60, 1'b1, 2'd2},
                 {8'h61, 1'b0, 2'd1}, {8'h62, 1'b1, 2'd2}, {8'h63, 1'b0, 2'd1}};
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 8'h60 + 8'(i), (i % 2) == 0);
            got = {Q, Q_VLD, COUNT};
            checks++;
            if (got !== want[i]) begin
                errors++; $display("FAIL alternate_edge%0d got=%h want=%h", i + 1, got, want[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] got;
        logic [10:0] exp;
        for (int i = 0; i < 60; i++) begin
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0,
                $urandom_range(0, 15) == 0, 8'($urandom), 1'($urandom));
            got = {Q, Q_VLD, COUNT};
            exp = model_out();
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL random_edge%0d got=%h want=%h", i, got, exp);
            end
        end
    endtask

`ifdef DFFN_PIPE_BANK_SCAN_EN
    task automatic test_scan();
        logic [26:0] pat;
        pat = 27'h5A5A5A5;
        EN = 1'b0; SET = 1'b0; FLUSH = 1'b0; D_VLD = 1'b0;
        SE = 1'b1;
        for (int k = 0; k < 27; k++) begin
            SI = pat[k];
            @(negedge CLK);
            #1;
        end
        for (int k = 0; k < 27; k++) begin
            checks++;
            if (SO !== pat[k]) begin
                errors++; $display("FAIL scan_out_bit%0d got=%b want=%b", k, SO, pat[k]);
            end
            SI = 1'b0;
            @(negedge CLK);
            #1;
        end
        SE = 1'b0;
        @(posedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        RST = 1'b0;
        model_reset();
        test_fill();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fill();
        test_stall();
        test_set_flush();
        test_alternate();
        test_back_to_back();
`ifdef DFFN_PIPE_BANK_SCAN_EN
        test_scan();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
